// File: rtl/bcd_to_bin_pkg.sv
// Shared BCD constants and state encoding for the BCD<->binary converters.
// Purely declarative: no latency, no flow control.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] CORR_THRESHOLD = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] CORR_SUB       = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/busy/done bundle between a converter client (master) and bcd_to_bin (slave).
// Start is only honoured while the converter is not busy; no queueing.
interface bcd_to_bin_if #(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
);
  import bcd_pkg::*;

  logic                           start;
  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_in;
  logic                           busy;
  logic                           done;
  logic [BIN_W-1:0]               bin_out;
  logic                           err;

  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin_digit_corr.sv
// One-digit reverse double-dabble correction: subtract 3 when the digit is >= 8.
// Combinational, zero latency, no flow control.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= CORR_THRESHOLD) ? (i_digit - CORR_SUB) : i_digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Multi-cycle BCD->binary (shift right, then correct digits); done pulses BIN_W cycles after accept.
// start ignored while busy; BCD_CHECK_EN adds invalid-digit detection (err, bin_out forced to 0).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_to_bin_if.slave  bus
);

  localparam int BCD_W = BCD_DIGIT_W * NDIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  bcd_state_t        r_state;
  bcd_state_t        w_state_next;
  logic [SR_W-1:0]   r_sr;
  logic [SR_W-1:0]   w_shifted;
  logic [SR_W-1:0]   w_sr_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIN_W-1:0]  r_bin;
  logic              w_accept;
  logic              w_last;

  // Digits are corrected after the shift, within the same edge.
  assign w_shifted              = r_sr >> 1;
  assign w_sr_next[BIN_W-1:0]   = w_shifted[BIN_W-1:0];

  for (genvar g = 0; g < NDIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit (w_shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_sr_next[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
          w_accept     = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
          w_last       = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sr  <= {bus.bcd_in, {BIN_W{1'b0}}};
      r_cnt <= CNT_W'(BIN_W - 1);
    end else if (r_state == ST_RUN) begin
      r_sr  <= w_sr_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef BCD_CHECK_EN
  logic r_err_q;
  logic r_err;
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (bus.bcd_in[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q <= 1'b0;
      r_err   <= 1'b0;
      r_bin   <= '0;
    end else begin
      if (w_accept) r_err_q <= w_bad;
      if (w_last) begin
        r_err <= r_err_q;
        r_bin <= r_err_q ? '0 : w_sr_next[BIN_W-1:0];
      end
    end
  end

  assign bus.err = r_err;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_bin <= '0;
    else if (w_last) r_bin <= w_sr_next[BIN_W-1:0];
  end

  assign bus.err = 1'b0;
`endif

  assign bus.busy    = (r_state == ST_RUN);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.bin_out = r_bin;

endmodule
